// File: rtl/data_exec_pipe.sv
// data_exec_pipe
//   Two-stage execute datapath: register file read with write-back
//   forwarding, ALU-source mux, ALU, and a registered W stage that writes
//   back to the register file on the following edge.
//
//   Optional feature macro: DATA_EXEC_MUL_EN
//     defined   : ALUctrl=111 runs an iterative shift-add multiplier
//                 (DATAWIDTH cycles) and holds in_ready low while busy.
//     undefined : no multiplier/FSM, in_ready tied high, ALUctrl=111
//                 completes in one cycle with result 0.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operation handshake
//     rs1, rs2, rd          source / destination register indices
//     RegWrite              write result to rd
//     ALUsrc                0: op2 = reg[rs2], 1: op2 = ImmOp
//     ALUctrl               ADD SUB AND OR XOR SLT SLL MUL
//     ImmOp                 immediate operand
//     out_valid             one-cycle pulse, result/EQ valid
//     result, EQ            registered ALU result and (op1 == op2)
//     a0                    committed content of reg[A0IDX]
module data_exec_pipe #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned REGWIDTH  = 5,
  parameter int unsigned A0IDX     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGWIDTH-1:0]  rs1,
  input  logic [REGWIDTH-1:0]  rs2,
  input  logic [REGWIDTH-1:0]  rd,
  input  logic                 RegWrite,
  input  logic                 ALUsrc,
  input  logic [2:0]           ALUctrl,
  input  logic [DATAWIDTH-1:0] ImmOp,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] result,
  output logic                 EQ,
  output logic [DATAWIDTH-1:0] a0
);

  localparam int unsigned NREGS = 1 << REGWIDTH;
  localparam int unsigned SHW   = $clog2(DATAWIDTH);
  localparam logic [REGWIDTH-1:0] A0SEL = REGWIDTH'(A0IDX);

  // Register file and W stage
  logic [DATAWIDTH-1:0] regs_q [NREGS];
  logic                 w_valid_q;
  logic                 w_we_q;
  logic [REGWIDTH-1:0]  w_rd_q;
  logic [DATAWIDTH-1:0] w_res_q;
  logic                 w_eq_q;

  // W-stage load request and payload
  logic                 w_load;
  logic [DATAWIDTH-1:0] w_load_res;
  logic                 w_load_eq;
  logic [REGWIDTH-1:0]  w_load_rd;
  logic                 w_load_we;

  logic [DATAWIDTH-1:0] op1, op2, rdata2, alu_res;
  logic                 op_eq;

  // Forwarding from W covers the same-edge write-back case: the value being
  // written this edge is the one read.
  always_comb begin
    op1 = '0;
    if (rs1 != '0) begin
      if (w_valid_q && w_we_q && (w_rd_q == rs1)) op1 = w_res_q;
      else                                       op1 = regs_q[rs1];
    end
    rdata2 = '0;
    if (rs2 != '0) begin
      if (w_valid_q && w_we_q && (w_rd_q == rs2)) rdata2 = w_res_q;
      else                                       rdata2 = regs_q[rs2];
    end
  end

  assign op2   = ALUsrc ? ImmOp : rdata2;
  assign op_eq = (op1 == op2);

  always_comb begin
    alu_res = '0;
    case (ALUctrl)
      3'b000:  alu_res = op1 + op2;
      3'b001:  alu_res = op1 - op2;
      3'b010:  alu_res = op1 & op2;
      3'b011:  alu_res = op1 | op2;
      3'b100:  alu_res = op1 ^ op2;
      3'b101:  alu_res = {{(DATAWIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b110:  alu_res = op1 << op2[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef DATA_EXEC_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] mcand_q, mcand_d;
  logic [DATAWIDTH-1:0] mplier_q, mplier_d;
  logic [DATAWIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [REGWIDTH-1:0]  m_rd_q, m_rd_d;
  logic                 m_we_q, m_we_d;
  logic                 m_eq_q, m_eq_d;
  logic [DATAWIDTH-1:0] acc_step;

  assign in_ready = (state_q == IDLE);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    m_rd_d     = m_rd_q;
    m_we_d     = m_we_q;
    m_eq_d     = m_eq_q;
    w_load     = 1'b0;
    w_load_res = alu_res;
    w_load_eq  = op_eq;
    w_load_rd  = rd;
    w_load_we  = RegWrite;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ALUctrl == 3'b111) begin
            mcand_d  = op1;
            mplier_d = op2;
            acc_d    = '0;
            cnt_d    = '0;
            m_rd_d   = rd;
            m_we_d   = RegWrite;
            m_eq_d   = op_eq;
            state_d  = BUSY;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // Last iteration: the accumulated sum including this edge's step
        // goes straight into W.
        if (cnt_q == SHW'(DATAWIDTH - 1)) begin
          w_load     = 1'b1;
          w_load_res = acc_step;
          w_load_eq  = m_eq_q;
          w_load_rd  = m_rd_q;
          w_load_we  = m_we_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      m_rd_q   <= '0;
      m_we_q   <= 1'b0;
      m_eq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      m_rd_q   <= m_rd_d;
      m_we_q   <= m_we_d;
      m_eq_q   <= m_eq_d;
    end
  end
`else
  assign in_ready   = 1'b1;
  assign w_load     = in_valid;
  assign w_load_res = alu_res;
  assign w_load_eq  = op_eq;
  assign w_load_rd  = rd;
  assign w_load_we  = RegWrite;
`endif

  // W stage: result/EQ hold their last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_q <= 1'b0;
      w_we_q    <= 1'b0;
      w_rd_q    <= '0;
      w_res_q   <= '0;
      w_eq_q    <= 1'b0;
    end else begin
      w_valid_q <= w_load;
      if (w_load) begin
        w_we_q  <= w_load_we;
        w_rd_q  <= w_load_rd;
        w_res_q <= w_load_res;
        w_eq_q  <= w_load_eq;
      end
    end
  end

  // Write-back on the edge following out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (w_valid_q && w_we_q && (w_rd_q != '0)) begin
      regs_q[w_rd_q] <= w_res_q;
    end
  end

  assign out_valid = w_valid_q;
  assign result    = w_res_q;
  assign EQ        = w_eq_q;
  assign a0        = regs_q[A0SEL];

endmodule

// File: doc/data_exec_pipe.md
# data_exec_pipe

Parametrised two-stage execute datapath: the next generation of the single-cycle register-file/ALU-source-mux/ALU datapath. It sits between decode and the top level. Decoded operations arrive under a valid/ready handshake. Results are registered, then written back to the register file one cycle later, with write-back forwarding. An optional iterative multiplier stalls the handshake while it runs.

## Interface
- DATAWIDTH, 32: register and ALU width (≥8, power of two)
- REGWIDTH, 5: register index width; 2^REGWIDTH registers, x0 hardwired zero
- A0IDX, 10: register index mirrored on a0
---
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation present
- in_ready  out  1  operation can be accepted
- rs1, rs2, rd  in  REGWIDTH  source and destination indices
- RegWrite  in  1  write result to rd
- ALUsrc  in  1  0: op2 = reg[rs2]; 1: op2 = ImmOp
- ALUctrl  in  3  operation select
- ImmOp  in  DATAWIDTH  immediate
- out_valid  out  1  one-cycle pulse; result/EQ valid
- result  out  DATAWIDTH  registered ALU result
- EQ  out  1  registered (op1 == op2)
- a0  out  DATAWIDTH  committed content of reg[A0IDX]

## Operation
- Accept = in_valid && in_ready.
- Operand read:
  - reg[rs] with forwarding: if W-stage valid, W.RegWrite, W.rd == rs and rs != 0, use W.result.
  - x0 always reads 0.
- ALUctrl:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLT: signed; result 1 or 0, zero-extended
  - 110 SLL: shift amount = op2[log2(DATAWIDTH)-1:0]
  - 111 MUL: low DATAWIDTH bits of the product, unsigned shift-add
- Arithmetic wraps modulo 2^DATAWIDTH; no flags other than EQ.
- FSM IDLE/BUSY:
  - IDLE: in_ready=1.
  - Accepted non-MUL: W loaded at that edge; stay IDLE.
  - Accepted MUL: capture mcand=op1, mplier=op2, acc=0, count=0, EQ compare; go BUSY.
  - BUSY: in_ready=0. Each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - On the DATAWIDTH-th BUSY edge: load W with the final acc, return to IDLE.
- W stage:
  - Holds valid, rd, RegWrite, result, EQ.
  - out_valid = W.valid.
  - On the edge after out_valid, reg[rd] <= result if RegWrite && rd != 0.
  - W.valid clears unless reloaded.
- result and EQ hold their last values when out_valid=0.
- a0 reflects reg[A0IDX] after write-back; forwarded values do not appear on a0.
- No output backpressure; out_valid cannot be stalled.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM=IDLE, W.valid=0, out_valid=0, result=0, EQ=0, all registers 0, a0=0.
  - in_ready=1 as soon as rst_n is high.
- Reset mid-MUL aborts it: no out_valid and no write-back.
- Non-MUL latency:
  - Accept at edge N gives out_valid in cycle N+1.
  - reg[rd] is written at edge N+1; a0 updates after N+1.
- Back-to-back accepts every cycle are allowed. A dependent op in cycle N+1 receives the forwarded result.
- MUL latency:
  - Accept at edge N; in_ready=0 in cycles N+1…N+DATAWIDTH.
  - out_valid in cycle N+DATAWIDTH+1; in_ready=1 again in that cycle.
- A W-stage write that is pending when a MUL is accepted completes normally during BUSY.
- Simultaneous write-back and read of the same register: forwarding wins, so the new value is read.

## Configuration
- DATA_EXEC_MUL_EN defined: MUL implemented as above.
- DATA_EXEC_MUL_EN undefined:
  - No FSM or multiplier logic; in_ready tied to 1.
  - ALUctrl=111 completes in 1 cycle with result=0; EQ and write-back still apply.

## Test plan
- ADD x1=x0+imm 5, then next cycle ADD x10=x1+x1 (ALUsrc=0) -> result 5 then 10 on consecutive cycles via forwarding; a0=10 one cycle after the second out_valid.
- SUB with op1=op2=0x1234 -> result 0, EQ=1. SLT 0xFFFFFFFF vs 1 -> result 1, EQ=0.
- RegWrite=1, rd=0, imm 0x55 -> out_valid=1, result 0x55; a later read of x0 returns 0.
- MUL 7×6 (DATAWIDTH=32) -> in_ready=0 for 32 cycles, out_valid 33 cycles after the input cycle, result 42. An in_valid held during BUSY is accepted on the cycle in_ready rises.
- rst_n low 10 cycles into a MUL -> out_valid never pulses, target register unchanged; in_ready=1 and a0=0 after release.
- Without DATA_EXEC_MUL_EN: ALUctrl=111 -> out_valid next cycle, result 0, in_ready never drops.
